// File: rtl/memory_access_pkg.sv
// Shared definitions for the memory-access stage: access-size encodings, FSM states
// and the byte-lane helpers used by both the stage and its bench.
package memory_access_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    // Illegal size or an address not aligned to the access size.
    function automatic logic access_fault(input logic [2:0] f3, input logic [1:0] lo);
        logic f;
        case (f3)
            F3_B, F3_BU: f = 1'b0;
            F3_H, F3_HU: f = lo[0];
            F3_W:        f = (lo != 2'b00);
            default:     f = 1'b1;
        endcase
        return f;
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] lo);
        logic [3:0] be;
        case (f3)
            F3_B, F3_BU: be = 4'b0001 << lo;
            F3_H, F3_HU: be = lo[1] ? 4'b1100 : 4'b0011;
            F3_W:        be = 4'b1111;
            default:     be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate the low-aligned store data so every candidate lane carries it.
    function automatic logic [31:0] store_align(input logic [1:0] size, input logic [31:0] d);
        logic [31:0] w;
        case (size)
            2'b00:   w = {4{d[7:0]}};
            2'b01:   w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] lo,
                                                 input logic [31:0] word);
        logic [15:0] sh;
        logic [31:0] r;
        sh = 16'(word >> {lo, 3'b000});
        case (f3)
            F3_B:    r = {{24{sh[7]}}, sh[7:0]};
            F3_BU:   r = {24'h0, sh[7:0]};
            F3_H:    r = {{16{sh[15]}}, sh[15:0]};
            F3_HU:   r = {16'h0, sh[15:0]};
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/memory_access_data_mem_array.sv
// Word-organised data memory: byte-enabled synchronous write, combinational read.
// Contents are deliberately not reset.
module data_mem_array #(
    parameter int DEPTH = 256,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/memory_access.sv
// Pipeline memory-access stage: multi-cycle loads/stores against a local data memory,
// single-cycle pass-through for non-memory instructions and faulting accesses.
module memory_access
    import memory_access_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        mem_to_reg_in,
    input  logic        reg_write_in,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] store_data_in,
    output logic        stall_out,
    output logic        valid_out,
    output logic        mem_to_reg_out,
    output logic        reg_write_out,
    output logic [4:0]  rd_out,
    output logic [31:0] alu_data_out,
    output logic [31:0] dm_data_out,
    output logic        misaligned_out,
    output state_t      fsm_state_o
);

    localparam int AW = $clog2(DEPTH);

    // Handshake: an instruction on valid_in is taken while the FSM is IDLE; for a memory
    // access stall_out rises in that same cycle and stays high through the commit cycle,
    // during which upstream keeps every input stable (the access reads them at commit).
    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        valid_q, m2r_q, rw_q, mis_q;
    logic [4:0]  rd_q;
    logic [31:0] alu_q, dm_q;

    logic          mem_op, is_store, fault, start, commit, we;
    logic [1:0]    lo;
    logic [AW-1:0] word_idx;
    logic [31:0]   rdata;
    logic          done_d, mis_d;
    logic [31:0]   dm_d;
    logic          unused_addr_bits;

    assign mem_op   = mem_read | mem_write;
    assign is_store = mem_write;
    assign lo       = alu_result_in[1:0];
    assign word_idx = alu_result_in[AW+1:2];
    assign unused_addr_bits = ^alu_result_in[31:AW+2];
    assign fault    = access_fault(funct3, lo);
    assign start    = (state_q == IDLE) && valid_in && mem_op && !fault;
    assign commit   = (state_q == WAIT) && (cnt_q == 4'd1);
    assign we       = commit && is_store && !reset;

    assign stall_out = start || (state_q == WAIT);

    data_mem_array #(.DEPTH(DEPTH)) u_mem (
        .clk_i  (clk),
        .we_i   (we),
        .be_i   (byte_en(funct3, lo)),
        .addr_i (word_idx),
        .wdata_i(store_align(funct3[1:0], store_data_in)),
        .rdata_o(rdata)
    );

    always_comb begin
        done_d = 1'b0;
        mis_d  = 1'b0;
        dm_d   = '0;
        if ((state_q == IDLE) && valid_in && (!mem_op || fault)) begin
            done_d = 1'b1;
            mis_d  = mem_op;
        end
        if (commit) begin
            done_d = 1'b1;
            dm_d   = is_store ? 32'h0 : load_extract(funct3, lo, rdata);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            m2r_q   <= 1'b0;
            rw_q    <= 1'b0;
            mis_q   <= 1'b0;
            rd_q    <= '0;
            alu_q   <= '0;
            dm_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= WAIT;
                        cnt_q   <= 4'(MEM_LATENCY);
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            valid_q <= done_d;
            mis_q   <= mis_d;
            if (done_d) begin
                m2r_q <= mem_to_reg_in;
                rw_q  <= reg_write_in && !mis_d;
                rd_q  <= rd_in;
                alu_q <= alu_result_in;
                dm_q  <= dm_d;
            end else begin
                m2r_q <= 1'b0;
                rw_q  <= 1'b0;
            end
        end
    end

    assign valid_out      = valid_q;
    assign mem_to_reg_out = m2r_q;
    assign reg_write_out  = rw_q;
    assign misaligned_out = mis_q;
    assign rd_out         = rd_q;
    assign alu_data_out   = alu_q;
    assign dm_data_out    = dm_q;
    assign fsm_state_o    = state_q;

endmodule

// File: tb/tb_memory_access.sv
// Scoreboard bench for memory_access: directed loads/stores, faults, reset abort,
// address wrap and a short random store/load sweep.
module tb_memory_access;
    import memory_access_pkg::*;

    localparam int EXP_W = 72;

    typedef struct packed {
        logic        mis;
        logic        rw;
        logic        m2r;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] dm;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid_in = 1'b0;
    logic        mem_read = 1'b0, mem_write = 1'b0;
    logic        mem_to_reg_in = 1'b0, reg_write_in = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [4:0]  rd_in = '0;
    logic [31:0] alu_result_in = '0, store_data_in = '0;
    logic        stall_out, valid_out, mem_to_reg_out, reg_write_out, misaligned_out;
    logic [4:0]  rd_out;
    logic [31:0] alu_data_out, dm_data_out;
    state_t      fsm_state_o;

    logic [EXP_W-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    memory_access #(.DEPTH(256), .MEM_LATENCY(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .valid_in      (valid_in),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_to_reg_in (mem_to_reg_in),
        .reg_write_in  (reg_write_in),
        .funct3        (funct3),
        .rd_in         (rd_in),
        .alu_result_in (alu_result_in),
        .store_data_in (store_data_in),
        .stall_out     (stall_out),
        .valid_out     (valid_out),
        .mem_to_reg_out(mem_to_reg_out),
        .reg_write_out (reg_write_out),
        .rd_out        (rd_out),
        .alu_data_out  (alu_data_out),
        .dm_data_out   (dm_data_out),
        .misaligned_out(misaligned_out),
        .fsm_state_o   (fsm_state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where the result is visible.
    task automatic do_op(input string tag, input logic rd_en, input logic wr_en,
                         input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] sdata, input logic [4:0] rd,
                         input logic m2r, input logic rw, input logic exp_mis,
                         input logic [31:0] exp_dm, input int exp_stalls);
        exp_t e;
        int   stalls;
        logic seen;
        valid_in      = 1'b1;
        mem_read      = rd_en;
        mem_write     = wr_en;
        funct3        = f3;
        alu_result_in = addr;
        store_data_in = sdata;
        rd_in         = rd;
        mem_to_reg_in = m2r;
        reg_write_in  = rw;
        e.mis = exp_mis;
        e.rw  = exp_mis ? 1'b0 : rw;
        e.m2r = m2r;
        e.rd  = rd;
        e.alu = addr;
        e.dm  = exp_dm;
        exp_q.push_back(e);
        stalls = 0;
        seen   = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            #1;
            if (stall_out) stalls++;
            @(negedge clk);
            if (valid_out) begin
                seen = 1'b1;
                check({tag, "_qsize"}, exp_q.size(), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check({tag, "_dm"}, dm_data_out, e.dm);
                    check({tag, "_alu"}, alu_data_out, e.alu);
                    check({tag, "_rd"}, 32'(rd_out), 32'(e.rd));
                    check({tag, "_ctl"}, {29'b0, misaligned_out, reg_write_out, mem_to_reg_out},
                          {29'b0, e.mis, e.rw, e.m2r});
                end
                check({tag, "_stalls"}, stalls, exp_stalls);
            end
        end
        if (!seen) begin
            check({tag, "_timeout"}, 32'(valid_out), 32'd1);
            exp_q.delete();
        end
    endtask

    task automatic idle_check(input string tag);
        valid_in  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(negedge clk);
        check({tag, "_idle"}, {30'b0, valid_out, reg_write_out}, 32'd0);
    endtask

    task automatic sw(input string tag, input logic [31:0] a, input logic [31:0] d);
        do_op(tag, 1'b0, 1'b1, F3_W, a, d, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 3);
    endtask

    task automatic ld(input string tag, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] exp_d);
        do_op(tag, 1'b1, 1'b0, f3, a, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, exp_d, 3);
    endtask

    initial begin
        logic [31:0] ra, rdat;
        repeat (2) @(negedge clk);
        check("rst_outs", {25'b0, valid_out, reg_write_out, mem_to_reg_out,
              misaligned_out, stall_out, 2'b0}, 32'd0);
        check("rst_data", alu_data_out | dm_data_out | 32'(rd_out), 32'd0);
        check("rst_fsm", 32'(fsm_state_o), 32'(IDLE));
        reset = 1'b0;
        @(negedge clk);

        do_op("nop", 1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0, 5'd5, 1'b0, 1'b1,
              1'b0, 32'h0, 0);
        idle_check("after_nop");

        sw("sw10", 32'h10, 32'hDEAD_BEEF);
        ld("lw10", F3_W, 32'h10, 32'hDEAD_BEEF);
        do_op("sb13", 1'b0, 1'b1, F3_B, 32'h13, 32'h1234_5680, 5'd0, 1'b0, 1'b0,
              1'b0, 32'h0, 3);
        ld("lb13", F3_B, 32'h13, 32'hFFFF_FF80);
        ld("lbu13", F3_BU, 32'h13, 32'h0000_0080);
        ld("lw10b", F3_W, 32'h10, 32'h80AD_BEEF);
        idle_check("after_lw");

        do_op("lw6_mis", 1'b1, 1'b0, F3_W, 32'h0000_0006, 32'h0, 5'd7, 1'b1, 1'b1,
              1'b1, 32'h0, 0);

        sw("sw40", 32'h40, 32'h1122_3344);
        do_op("sh42", 1'b0, 1'b1, F3_H, 32'h42, 32'hFFFF_8001, 5'd0, 1'b0, 1'b0,
              1'b0, 32'h0, 3);
        ld("lh42", F3_H, 32'h42, 32'hFFFF_8001);
        ld("lhu42", F3_HU, 32'h42, 32'h0000_8001);
        do_op("sh41_mis", 1'b0, 1'b1, F3_H, 32'h41, 32'h0000_AAAA, 5'd0, 1'b0, 1'b0,
              1'b1, 32'h0, 0);
        do_op("sw12_mis", 1'b0, 1'b1, F3_W, 32'h12, 32'h0BAD_0BAD, 5'd0, 1'b0, 1'b0,
              1'b1, 32'h0, 0);
        do_op("f3_011", 1'b1, 1'b0, 3'b011, 32'h40, 32'h0, 5'd3, 1'b1, 1'b1,
              1'b1, 32'h0, 0);
        ld("lw40", F3_W, 32'h40, 32'h8001_3344);
        ld("lw10c", F3_W, 32'h10, 32'h80AD_BEEF);
        ld("lb41", F3_B, 32'h41, 32'h0000_0033);

        do_op("rw_both", 1'b1, 1'b1, F3_W, 32'h30, 32'h5A5A_1234, 5'd4, 1'b1, 1'b0,
              1'b0, 32'h0, 3);
        ld("lw30", F3_W, 32'h30, 32'h5A5A_1234);

        sw("sw400", 32'h400, 32'h0000_0055);
        ld("lw0_wrap", F3_W, 32'h0, 32'h0000_0055);

        sw("sw20", 32'h20, 32'hCAFE_F00D);
        valid_in      = 1'b1;
        mem_read      = 1'b0;
        mem_write     = 1'b1;
        funct3        = F3_W;
        alu_result_in = 32'h20;
        store_data_in = 32'h0000_0001;
        @(negedge clk);
        check("abort_in_wait", 32'(fsm_state_o), 32'(WAIT));
        reset    = 1'b1;
        valid_in = 1'b0;
        @(negedge clk);
        check("abort_valid", {30'b0, valid_out, stall_out}, 32'd0);
        check("abort_fsm", 32'(fsm_state_o), 32'(IDLE));
        reset = 1'b0;
        idle_check("abort_1");
        idle_check("abort_2");
        ld("lw20_abort", F3_W, 32'h20, 32'hCAFE_F00D);

        for (int i = 0; i < 8; i++) begin
            ra   = 32'($urandom_range(0, 255)) << 2;
            rdat = $urandom;
            sw("rnd_sw", ra, rdat);
            ld("rnd_lw", F3_W, ra, rdat);
        end
        idle_check("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
